instruction_memory: RTL

- Parametrised instruction store for the network sequencer; successor to the fixed 8-bit, combinational-read instruction ROM.
- Adds a registered read port with a valid strobe, and a streaming program loader (valid/ready) that writes a contiguous address range at run time.
- Out-of-range and conflicting accesses are flagged instead of returning undefined data.
- Sits between the program loader/host interface and the sequencer fetch stage.

---
 rtl/instruction_memory.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/instruction_memory.sv
// Parametrised instruction store: registered read port plus a streaming valid/ready program loader.
// Optional per-word even parity (macro INSTR_MEM_PARITY_EN) adds the parity_err output.
module instruction_memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 128,
    parameter int INIT_VALUE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_err,
    input  logic                  ld_start,
    input  logic [ADDR_WIDTH-1:0] ld_base,
    input  logic [ADDR_WIDTH:0]   ld_count,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ready,
    output logic                  ld_busy,
    output logic                  ld_done,
`ifdef INSTR_MEM_PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  ld_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DATA_WIDTH-1:0] INIT_WORD = DATA_WIDTH'(INIT_VALUE);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    // Power-up content only; reset deliberately leaves the array alone.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: INIT_WORD};
`ifdef INSTR_MEM_PARITY_EN
    logic                  par_mem [DEPTH] = '{default: ^INIT_WORD};
`endif

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   rem;
    logic [ADDR_WIDTH+1:0] ld_end;
    logic                  ld_over;
    logic                  rd_oor;
    logic                  wr_en;

    // One bit wider than the operands so base+count can never wrap.
    assign ld_end  = {2'b00, ld_base} + {1'b0, ld_count};
    assign ld_over = ld_end > (ADDR_WIDTH+2)'(DEPTH);
    assign rd_oor  = {1'b0, rd_addr} >= (ADDR_WIDTH+1)'(DEPTH);
    assign wr_en   = !rst && (state == LOAD) && ld_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (ld_start) begin
                if (ld_count == '0) state_nx = DONE;
                else if (!ld_over)  state_nx = LOAD;
            end
            LOAD: if (ld_valid && rem == (ADDR_WIDTH+1)'(1)) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ld_ready = 1'b0;
        ld_busy  = 1'b0;
        ld_done  = 1'b0;
        case (state)
            LOAD: begin ld_ready = 1'b1; ld_busy = 1'b1; end
            DONE: begin ld_done  = 1'b1; ld_busy = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            rem    <= '0;
            ld_err <= 1'b0;
        end else begin
            ld_err <= 1'b0;
            if (state == IDLE && ld_start && ld_count != '0) begin
                if (ld_over) begin
                    ld_err <= 1'b1;
                end else begin
                    ptr <= ld_base;
                    rem <= ld_count;
                end
            end else if (state == LOAD && ld_valid) begin
                ptr <= ptr + ADDR_WIDTH'(1);
                rem <= rem - (ADDR_WIDTH+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr[IW-1:0]] <= ld_data;
`ifdef INSTR_MEM_PARITY_EN
            par_mem[ptr[IW-1:0]] <= ^ld_data;
`endif
        end
    end

    // A read while busy is rejected without touching rd_data; out-of-range zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
`ifdef INSTR_MEM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
`ifdef INSTR_MEM_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (rd_en) begin
                if (ld_busy) begin
                    rd_err <= 1'b1;
                end else if (rd_oor) begin
                    rd_err  <= 1'b1;
                    rd_data <= '0;
                end else begin
                    rd_valid <= 1'b1;
                    rd_data  <= mem[rd_addr[IW-1:0]];
`ifdef INSTR_MEM_PARITY_EN
                    parity_err <= par_mem[rd_addr[IW-1:0]] != ^mem[rd_addr[IW-1:0]];
`endif
                end
            end
        end
    end

endmodule
